// File: rtl/gesture_level_tracker.sv
//------------------------------------------------------------------------------
// Module   : gesture_level_tracker
// Brief    : Frame-timed gesture-to-level controller. A detected marker selects
//            a channel; its vertical motion steps that channel's level with
//            saturation. Optional feature macro: TRACKER_DEADZONE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gesture_level_tracker #(
  parameter int                       NUM_CH      = 3,
  parameter int                       CH_W        = 8,
  parameter int                       WAIT_FRAMES = 60,
  parameter int                       DELTA_SHIFT = 0,
  parameter int                       TICK_H      = 10,
  parameter int                       TICK_V      = 10,
  parameter logic [NUM_CH*CH_W-1:0]   RESET_LEVEL = 'h040000,
  parameter int                       DEADZONE    = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic [$clog2(NUM_CH+1)-1:0]   detected_in,
  input  logic [10:0]                   xtrack_in,
  input  logic [9:0]                    ytrack_in,
  output logic [NUM_CH*CH_W-1:0]        level_out,
  output logic [$clog2(NUM_CH)-1:0]     active_ch_out,
  output logic                          state_out,
  output logic                          data_valid_out
);

  localparam int CW = $clog2(NUM_CH+1);
  localparam int AW = $clog2(NUM_CH);
  localparam int SW = CH_W + 12;

  localparam logic [CW-1:0]        c_num_ch = CW'(NUM_CH);
  localparam logic [6:0]           c_wait   = 7'(WAIT_FRAMES);
  localparam logic signed [SW-1:0] c_max    = SW'((64'd1 << CH_W) - 64'd1);

  typedef enum logic [0:0] {
    ST_REST  = 1'b0,
    ST_WATCH = 1'b1
  } state_t;

  state_t          r_state;
  logic [CH_W-1:0] r_lvl [NUM_CH];
  logic [AW-1:0]   r_active;
  logic [6:0]      r_frame_cnt;
  logic [9:0]      r_y_old;
  logic [10:0]     r_unused_x_old;
  logic            r_publish;
  logic            r_valid;

  logic                 w_tick;
  logic                 w_code_ok;
  logic [CW-1:0]        w_code_m1;
  logic [AW-1:0]        w_code_ch;
  logic                 w_same;
  logic [CH_W-1:0]      w_cur;
  logic signed [10:0]   w_delta;
  logic signed [10:0]   w_scaled;
  logic signed [SW-1:0] w_sum;
  logic [CH_W-1:0]      w_new;
  logic                 w_big;
  logic                 w_changed;

  assign w_tick    = (hcount_in == 11'(TICK_H)) && (vcount_in == 10'(TICK_V));
  assign w_code_ok = (detected_in != '0) && (detected_in <= c_num_ch);
  assign w_code_m1 = detected_in - CW'(1);
  assign w_code_ch = w_code_m1[AW-1:0];
  assign w_same    = w_code_ok && (w_code_ch == r_active);
  assign w_cur     = r_lvl[r_active];

  // Upward motion (smaller row number) gives a positive step.
  assign w_delta  = $signed({1'b0, r_y_old} - {1'b0, ytrack_in});
  assign w_scaled = w_delta >>> DELTA_SHIFT;
  assign w_sum    = $signed({{(SW-CH_W){1'b0}}, w_cur})
                  + $signed({{(SW-11){w_scaled[10]}}, w_scaled});
  assign w_new    = w_sum[SW-1]      ? '0 :
                    (w_sum > c_max)  ? '1 : w_sum[CH_W-1:0];

`ifdef TRACKER_DEADZONE_EN
  logic [10:0] w_abs;
  assign w_abs = w_scaled[10] ? $unsigned(-w_scaled) : $unsigned(w_scaled);
  assign w_big = (32'(w_abs) >= DEADZONE);
`else
  logic [31:0] w_unused_dz;
  assign w_unused_dz = 32'(DEADZONE);
  assign w_big       = 1'b1;
`endif

  assign w_changed = w_big && (w_new != w_cur);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state        <= ST_REST;
      r_active       <= '0;
      r_frame_cnt    <= '0;
      r_y_old        <= '0;
      r_unused_x_old <= '0;
      r_publish      <= 1'b1;
      r_valid        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lvl[c] <= RESET_LEVEL[(NUM_CH-1-c)*CH_W +: CH_W];
      end
    end else begin
      // The reset value is announced once on the first cycle out of reset.
      r_valid   <= r_publish;
      r_publish <= 1'b0;
      case (r_state)
        ST_REST: begin
          r_frame_cnt <= '0;
          if (w_code_ok) begin
            r_state        <= ST_WATCH;
            r_active       <= w_code_ch;
            r_y_old        <= ytrack_in;
            r_unused_x_old <= xtrack_in;
          end
        end
        ST_WATCH: begin
          if (r_frame_cnt >= c_wait) begin
            r_state     <= ST_REST;
            r_active    <= '0;
            r_frame_cnt <= '0;
          end else if (w_code_ok && !w_same) begin
            r_active       <= w_code_ch;
            r_y_old        <= ytrack_in;
            r_unused_x_old <= xtrack_in;
            r_frame_cnt    <= '0;
          end else if (w_same && (r_frame_cnt != '0)) begin
            r_frame_cnt    <= '0;
            r_y_old        <= ytrack_in;
            r_unused_x_old <= xtrack_in;
            if (w_changed) begin
              r_lvl[r_active] <= w_new;
              r_valid         <= 1'b1;
            end
          end else if (w_tick && (r_frame_cnt != 7'd127)) begin
            r_frame_cnt <= r_frame_cnt + 7'd1;
          end
        end
        default: r_state <= ST_REST;
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
      assign level_out[(NUM_CH-1-c)*CH_W +: CH_W] = r_lvl[c];
    end
  endgenerate

  assign active_ch_out  = r_active;
  assign state_out      = (r_state == ST_WATCH);
  assign data_valid_out = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_gesture_level_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_gesture_level_tracker
// Brief    : Directed bench for gesture_level_tracker with a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gesture_level_tracker;

  localparam int WAIT = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [1:0]  detected = '0;
  logic [10:0] xtrack = '0;
  logic [9:0]  ytrack = '0;
  logic [23:0] level_out;
  logic [1:0]  active_ch_out;
  logic        state_out;
  logic        data_valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  gesture_level_tracker dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .detected_in    (detected),
    .xtrack_in      (xtrack),
    .ytrack_in      (ytrack),
    .level_out      (level_out),
    .active_ch_out  (active_ch_out),
    .state_out      (state_out),
    .data_valid_out (data_valid_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer levels, clamp by plain comparison.
  int  m_lvl [3];
  bit  m_watch, m_dv, m_pub, m_started;
  int  m_ch, m_fc, m_yold;
  int  code, ds, nl;
  bit  ok, tk;

  always @(posedge clk) begin
    m_started = 1'b1;
    code = int'(detected);
    ok   = (code >= 1) && (code <= 3);
    tk   = (hcount == 11'd10) && (vcount == 10'd10);
    if (!rst) begin
      m_lvl[0] = 'h04; m_lvl[1] = 0; m_lvl[2] = 0;
      m_watch = 0; m_ch = 0; m_fc = 0; m_yold = 0; m_dv = 0; m_pub = 1;
    end else begin
      m_dv  = m_pub;
      m_pub = 0;
      if (!m_watch) begin
        m_fc = 0;
        if (ok) begin m_watch = 1; m_ch = code - 1; m_yold = int'(ytrack); end
      end else if (m_fc >= WAIT) begin
        m_watch = 0; m_ch = 0; m_fc = 0;
      end else if (ok && (code - 1 != m_ch)) begin
        m_ch = code - 1; m_yold = int'(ytrack); m_fc = 0;
      end else if (ok && m_fc >= 1) begin
        ds = m_yold - int'(ytrack);
        m_yold = int'(ytrack);
        m_fc = 0;
        nl = m_lvl[m_ch] + ds;
        if (nl < 0) nl = 0;
        if (nl > 255) nl = 255;
`ifdef TRACKER_DEADZONE_EN
        if (ds < 2 && ds > -2) nl = m_lvl[m_ch];
`endif
        if (nl != m_lvl[m_ch]) begin m_lvl[m_ch] = nl; m_dv = 1; end
      end else if (tk && m_fc < 127) begin
        m_fc = m_fc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_lvl;
    if (m_started) begin
      exp_lvl = {m_lvl[0][7:0], m_lvl[1][7:0], m_lvl[2][7:0]};
      n_cmp++;
      if (level_out !== exp_lvl || state_out !== m_watch ||
          active_ch_out !== 2'(m_ch) || data_valid_out !== m_dv) begin
        n_bad++;
        $display("FAIL model t=%0t: got lvl=%h st=%b ch=%0d dv=%b, want lvl=%h st=%b ch=%0d dv=%b",
                 $time, level_out, state_out, active_ch_out, data_valid_out,
                 exp_lvl, m_watch, m_ch, m_dv);
      end
    end
  end

  task automatic cyc(input int det, input int y, input bit tick);
    detected = det[1:0];
    ytrack   = y[9:0];
    xtrack   = 11'(y + 5);
    hcount   = tick ? 11'd10 : 11'd0;
    vcount   = tick ? 10'd10 : 10'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic frame_tick();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    check("reset_level", 32'(level_out), 32'h040000);
    check("reset_pulse", 32'(data_valid_out), 32'd1);
    check("reset_state", 32'(state_out), 32'd0);
    cyc(0, 0, 0);
    check("reset_pulse_once", 32'(data_valid_out), 32'd0);

    // ch0 arm at 300, next frame 280: +20
    cyc(1, 300, 0);
    check("arm_state", 32'(state_out), 32'd1);
    check("arm_nostrobe", 32'(data_valid_out), 32'd0);
    frame_tick();
    cyc(1, 280, 0);
    check("ch0_step", 32'(level_out), 32'h180000);
    check("ch0_strobe", 32'(data_valid_out), 32'd1);

    // ch1 up to 0xF0, clamp high, then down and clamp low
    cyc(2, 500, 0);
    check("switch_ch1", 32'(active_ch_out), 32'd1);
    frame_tick();  cyc(2, 260, 0);
    check("ch1_f0", 32'(level_out), 32'h18F000);
    frame_tick();  cyc(2, 220, 0);
    check("ch1_clamp_hi", 32'(level_out), 32'h18FF00);
    frame_tick();  cyc(2, 459, 0);
    check("ch1_10", 32'(level_out), 32'h181000);
    frame_tick();  cyc(2, 759, 0);
    check("ch1_clamp_lo", 32'(level_out), 32'h180000);
    frame_tick();  cyc(2, 759, 0);
    check("zero_delta_nostrobe", 32'(data_valid_out), 32'd0);

    // one sample per frame; tick coinciding with accept clears the counter
    frame_tick();  cyc(2, 749, 0);
    check("ch1_0a", 32'(level_out), 32'h180A00);
    cyc(2, 600, 0);
    check("same_frame_ignored", 32'(level_out), 32'h180A00);
    cyc(0, 0, 1);
    cyc(2, 739, 1);
    cyc(2, 729, 0);
    check("tick_accept", 32'(level_out), 32'h181400);

    cyc(1, 400, 0);
    cyc(2, 300, 0);
    check("switch_back_ch1", 32'(active_ch_out), 32'd1);
    check("switch_nostrobe", 32'(data_valid_out), 32'd0);

    // ch2 timeout after WAIT frames without a sample
    cyc(3, 100, 0);
    repeat (WAIT - 1) frame_tick();
    check("before_timeout", 32'(state_out), 32'd1);
    frame_tick();
    check("timeout_rest", 32'(state_out), 32'd0);
    check("timeout_ch0", 32'(active_ch_out), 32'd0);
    cyc(3, 50, 0);
    check("rearm_ch2", 32'(active_ch_out), 32'd2);
    check("rearm_level", 32'(level_out), 32'h181400);
    repeat (WAIT - 1) frame_tick();
    cyc(3, 40, 0);
    check("last_frame_accept", 32'(level_out), 32'h18140A);

`ifdef TRACKER_DEADZONE_EN
    frame_tick();  cyc(3, 39, 0);
    check("dz_small", 32'(level_out), 32'h18140A);
    check("dz_nostrobe", 32'(data_valid_out), 32'd0);
    frame_tick();  cyc(3, 37, 0);
    check("dz_apply", 32'(level_out), 32'h18140C);
`endif

    // reset while watching
    cyc(3, 10, 1);
    rst = 1'b0;
    cyc(3, 5, 0);
    cyc(0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    check("rereset_level", 32'(level_out), 32'h040000);
    check("rereset_state", 32'(state_out), 32'd0);
    check("rereset_pulse", 32'(data_valid_out), 32'd1);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
